mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Clocked two-requester arbiter that owns the select line of the team's gate-level 2:1 multiplexer (`mux2`) and shares that single-bit channel between two sources. It applies round-robin priority with a bounded burst length and a one-cycle turnaround between owners. It also registers the multiplexer output with a valid flag for the downstream consumer.

## Interface
Parameters:
- `MAX_BURST`, 4: maximum consecutive grant cycles per ownership while the other side waits; legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`  in  1  requester 0 wants the channel.
- `req1`  in  1  requester 1 wants the channel.
- `d0`  in  1  data bit from requester 0, to `mux2` input 0.
- `d1`  in  1  data bit from requester 1, to `mux2` input 1.
- `gnt0`  out  1  registered; requester 0 owns the channel this cycle.
- `gnt1`  out  1  registered; requester 1 owns the channel this cycle.
- `sel`  out  1  registered; drives `mux2` select; 0 selects `d0`.
- `z_q`  out  1  registered sample of the `mux2` output.
- `z_vld`  out  1  registered; `z_q` holds a granted data bit.

## Operation
- States: IDLE, OWN0, OWN1.
- Internal registers:
  - `last`: owner of the most recent grant.
  - `cnt`: burst counter, `$clog2(MAX_BURST+1)` bits.
- IDLE:
  - `gnt0` = `gnt1` = 0.
  - `sel` holds its previous value.
  - Only `req0` high: go to OWN0. Only `req1` high: go to OWN1. Both high: grant the side that is not `last`. Neither high: stay in IDLE.
- OWN0 / OWN1:
  - `gntX` = 1 and `sel` = X.
  - `cnt` increments once per owned cycle, starting at 1 on entry.
- Release: the state goes to IDLE on the next edge when either of these holds:
  - the owner's `reqX` is sampled low, or
  - `cnt == MAX_BURST` and the other side's request is sampled high.
- No release while alone: if `cnt == MAX_BURST` and the other side is not requesting, ownership continues and `cnt` holds at `MAX_BURST` (saturating, no wrap).
- On entry to OWNX, `last` is set to X.
- Turnaround: every release passes through exactly one IDLE cycle. `gnt0` and `gnt1` are never high in the same cycle, and never high in consecutive cycles for different owners.
- Data path:
  - Each cycle, `z_q` is updated with the `mux2` output.
  - `z_vld` is set to 1 if `gnt0|gnt1` was high in that cycle, otherwise 0.
  - `z_q` is don't-care when `z_vld` = 0.
- Reset mid-operation: all state is cleared immediately and asynchronously. The first arbitration after reset behaves as if `last` = 1, so requester 0 wins a tie.

## Timing
- Reset values: state = IDLE, `gnt0` = 0, `gnt1` = 0, `sel` = 0, `z_q` = 0, `z_vld` = 0, `cnt` = 0, `last` = 1.
- Request to grant: `reqX` sampled high in IDLE at edge N gives `gntX` and `sel` valid after edge N+1. Latency is 1 cycle.
- Data to output: the data bit presented while `gntX` is high during cycle N (between edges N and N+1) appears on `z_q`, with `z_vld` = 1, after edge N+1.
- `sel` changes only on the IDLE-to-OWN edge. The `mux2` output therefore has one full cycle to settle before the first valid sample.
- Clock period must exceed the `mux2` propagation delay of 10 time units plus register setup.
- Requester dropping: `req` deasserting while owned loses exactly the cycle in which it was sampled low. The grant is still high during that cycle.

## Structure
- Shared package `arb_pkg`: state enum `arb_state_t` {IDLE, OWN0, OWN1}, and constant `ARB_MAX_BURST_LIMIT` = 15.
- One sub-module, the existing gate-level `mux2`:
  - inputs `d0`, `d1`;
  - select driven by the `sel` register;
  - output goes to the `z_q` register.
- All arbitration logic is behavioural RTL in `mux2_arbiter`.

## Test plan
- Reset: `rst_n` = 0 with both requests high → all outputs 0, `sel` = 0. Release reset → `gnt0` = 1 one cycle later.
- Single requester: `req1` = 1 for 3 cycles, `d1` = 1,0,1 → `gnt1` high 3 cycles, `sel` = 1, then `z_q` = 1,0,1 with `z_vld` = 1, each one cycle after the corresponding grant cycle.
- Contention, `MAX_BURST` = 4: both requests held high → pattern `gnt0`×4, idle×1, `gnt1`×4, idle×1, repeating. Never an overlap.
- Saturation: only `req0` high for 10 cycles → `gnt0` continuous for 10 cycles, no idle gap, `cnt` stays at 4.
- Early release: `req0` drops after 2 grant cycles while `req1` is waiting → one IDLE cycle, then `gnt1`. `z_vld` = 0 for the IDLE sample.
- Async reset mid-burst: `rst_n` pulsed low during OWN1 → `gnt1` and `sel` go to 0 without a clock edge. Arbitration restarts with requester 0 favoured on a tie.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter state encoding and parameter limits.
//   No ports; provides arb_state_t and ARB_MAX_BURST_LIMIT.
package arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
   localparam int ARB_MAX_BURST_LIMIT = 15;
endpackage

// File: rtl/mux2.sv
// mux2: gate-level 2:1 multiplexer.
//   d0, d1 : data inputs
//   sel    : select, 0 picks d0
//   z      : selected data
module mux2 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic z
);
   logic sel_n, a0, a1;
   not u_inv (sel_n, sel);
   and u_and0 (a0, d0, sel_n);
   and u_and1 (a1, d1, sel);
   or  u_or (z, a0, a1);
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin two-requester owner of a mux2 select line with
// bounded bursts, one-cycle turnaround and a registered, flagged output.
//   clk, rst_n : clock, asynchronous active-low reset
//   req0, req1 : channel requests
//   d0, d1     : data bits routed through mux2
//   gnt0, gnt1 : registered grants
//   sel        : registered mux2 select
//   z_q, z_vld : registered mux2 output and its valid flag
module mux2_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic d0,
   input  logic d1,
   output logic gnt0,
   output logic gnt1,
   output logic sel,
   output logic z_q,
   output logic z_vld
);
   localparam int CW = $clog2(MAX_BURST + 1);
   arb_state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic last, at_max, z;
   mux2 u_mux (.d0(d0), .d1(d1), .sel(sel), .z(z));
   assign at_max = (cnt == CW'(MAX_BURST));
   // A tie in IDLE goes to the side that did not own last; a full burst
   // only ends when the other side is actually waiting.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (req0 && (!req1 || last)) ? OWN0 : req1 ? OWN1 : IDLE;
         OWN0:    state_nx = (!req0 || (at_max && req1)) ? IDLE : OWN0;
         OWN1:    state_nx = (!req1 || (at_max && req0)) ? IDLE : OWN1;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         sel   <= 1'b0;
         last  <= 1'b1;
         cnt   <= '0;
         z_q   <= 1'b0;
         z_vld <= 1'b0;
      end else begin
         state <= state_nx;
         gnt0  <= (state_nx == OWN0);
         gnt1  <= (state_nx == OWN1);
         sel   <= (state_nx == OWN1) ? 1'b1 : (state_nx == OWN0) ? 1'b0 : sel;
         last  <= (state_nx == OWN1) ? 1'b1 : (state_nx == OWN0) ? 1'b0 : last;
         // Owners only change through IDLE, so leaving IDLE marks a fresh burst.
         cnt   <= (state_nx == IDLE) ? '0 : (state == IDLE) ? CW'(1) : at_max ? cnt : cnt + 1'b1;
         z_q   <= z;
         z_vld <= gnt0 | gnt1;
      end
   end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed self-checking bench for mux2_arbiter.
module tb_mux2_arbiter;
   logic clk = 0, rst_n = 0, req0 = 0, req1 = 0, d0 = 0, d1 = 0;
   logic gnt0, gnt1, sel, z_q, z_vld;
   int checks = 0, errors = 0;

   mux2_arbiter #(.MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
      .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .z_q(z_q), .z_vld(z_vld)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req0 = 0; req1 = 0; d0 = 0; d1 = 0;
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 0; req0 = 1; req1 = 1;
      tick();
      tick();
      checks++;
      if ({gnt0, gnt1, sel, z_q, z_vld} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 00000", {gnt0, gnt1, sel, z_q, z_vld});
      end
      rst_n = 1;
      tick();
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_grant got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
      end
      req0 = 0; req1 = 0;
      tick();
      tick();
   endtask

   task automatic test_single();
      logic [0:3] ez, eg, ev;
      logic [0:2] dv;
      ez = 4'b0101; eg = 4'b1110; ev = 4'b0111; dv = 3'b101;
      do_reset();
      req1 = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (gnt1 !== eg[i] || gnt0 !== 1'b0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL single_grant[%0d] got gnt1=%b gnt0=%b sel=%b want %b 0 1", i, gnt1, gnt0, sel, eg[i]);
         end
         checks++;
         if (z_vld !== ev[i] || (ev[i] && z_q !== ez[i])) begin
            errors++;
            $display("FAIL single_data[%0d] got z_q=%b z_vld=%b want %b %b", i, z_q, z_vld, ez[i], ev[i]);
         end
         if (i < 3) d1 = dv[i];
         if (i == 2) req1 = 0;
      end
      tick();
      checks++;
      if (z_vld !== 1'b0) begin
         errors++;
         $display("FAIL single_vld_drop got %b want 0", z_vld);
      end
   endtask

   task automatic test_contention();
      logic [0:11] e0, e1;
      e0 = 12'b111100000011;
      e1 = 12'b000001111000;
      do_reset();
      req0 = 1; req1 = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (gnt0 !== e0[i] || gnt1 !== e1[i]) begin
            errors++;
            $display("FAIL contention[%0d] got gnt0=%b gnt1=%b want %b %b", i, gnt0, gnt1, e0[i], e1[i]);
         end
      end
      req0 = 0; req1 = 0;
   endtask

   task automatic test_saturation();
      do_reset();
      req0 = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL saturation[%0d] got gnt0=%b gnt1=%b want 1 0", i, gnt0, gnt1);
         end
      end
      checks++;
      if (int'(dut.cnt) != 4) begin
         errors++;
         $display("FAIL saturation_cnt got %0d want 4", int'(dut.cnt));
      end
      req0 = 0;
   endtask

   task automatic test_early_release();
      do_reset();
      req0 = 1; req1 = 1;
      tick();
      tick();
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL early_own0 got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
      end
      req0 = 0;
      tick();
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || z_vld !== 1'b1) begin
         errors++;
         $display("FAIL early_idle got gnt0=%b gnt1=%b z_vld=%b want 0 0 1", gnt0, gnt1, z_vld);
      end
      tick();
      checks++;
      if (gnt1 !== 1'b1 || sel !== 1'b1 || z_vld !== 1'b0) begin
         errors++;
         $display("FAIL early_handover got gnt1=%b sel=%b z_vld=%b want 1 1 0", gnt1, sel, z_vld);
      end
      req1 = 0;
   endtask

   task automatic test_async_reset();
      do_reset();
      req1 = 1;
      tick();
      checks++;
      if (gnt1 !== 1'b1 || sel !== 1'b1) begin
         errors++;
         $display("FAIL async_own1 got gnt1=%b sel=%b want 1 1", gnt1, sel);
      end
      req0 = 1;
      #3 rst_n = 0;
      #1;
      checks++;
      if (gnt1 !== 1'b0 || sel !== 1'b0 || gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL async_clear got gnt0=%b gnt1=%b sel=%b want 0 0 0", gnt0, gnt1, sel);
      end
      @(negedge clk);
      rst_n = 1;
      tick();
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL async_tie got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
      end
      req0 = 0; req1 = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_saturation();
      test_early_release();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
